// File: rtl/leaf_arb_pkg.sv
// Shared types and constants for the leaf stream arbiter and the leaf wrappers.
// Holds the arbiter FSM encoding, a constant clog2 helper and the default payload width.
package leaf_arb_pkg;

    localparam int DEFAULT_PAYLOAD_BITS = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/leaf_stream_arbiter_rr_pick.sv
// rr_priority_pick: combinational search for the first set request bit,
// starting at i_ptr and wrapping modulo N. o_any flags that any bit was set.
module rr_priority_pick #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        i_req,
    input  logic [IDX_BITS-1:0] i_ptr,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_any
);

    int   w_j;
    logic w_found;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && i_req[w_j]) begin
                o_idx   = IDX_BITS'(w_j);
                w_found = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/leaf_stream_arbiter.sv
// Burst-locked round-robin arbiter sharing one leaf user-to-interface port between NUM_REQ streams.
// Optional per-requester beat counters (stat_beats / stat_clr) are built when ARB_STATS_EN is defined.
module leaf_stream_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int REQ_BITS     = 2,
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int BURST_LEN    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout_leaf_user2interface,
    output logic                            vld_user2interface,
    input  logic                            ack_interface2user,
    output logic [REQ_BITS-1:0]             grant_idx,
    output logic                            busy
`ifdef ARB_STATS_EN
    ,
    input  logic                            stat_clr,
    output logic [NUM_REQ*32-1:0]           stat_beats
`endif
);

    localparam int CNT_BITS = clog2(BURST_LEN + 1);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);
    localparam logic [REQ_BITS-1:0] LAST_REQ  = REQ_BITS'(NUM_REQ - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [REQ_BITS-1:0] r_rr_ptr;
    logic [REQ_BITS-1:0] r_grant_idx;
    logic [CNT_BITS-1:0] r_beat_cnt;
    logic [REQ_BITS-1:0] w_pick_idx;
    logic [REQ_BITS-1:0] w_ptr_after;
    logic                w_pick_any;
    logic                w_granted;
    logic                w_sel_vld;
    logic                w_xfer;
    logic                w_release;

    rr_priority_pick #(
        .N        (NUM_REQ),
        .IDX_BITS (REQ_BITS)
    ) u_pick (
        .i_req (vld_req),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Reset gates the pass-through so no beat can transfer on a reset cycle.
    assign w_granted   = (r_state == GRANT) && !reset;
    assign w_sel_vld   = vld_req[r_grant_idx];
    assign w_xfer      = w_granted && w_sel_vld && ack_interface2user;
    assign w_release   = w_granted && (!w_sel_vld || (w_xfer && (r_beat_cnt == LAST_BEAT)));
    assign w_ptr_after = (r_grant_idx == LAST_REQ) ? '0 : r_grant_idx + REQ_BITS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && w_pick_any) begin
                r_grant_idx <= w_pick_idx;
                r_beat_cnt  <= '0;
            end
            if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + CNT_BITS'(1);
            end
            if (w_release) begin
                r_rr_ptr <= w_ptr_after;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_state_next = GRANT;
            GRANT:   if (w_release)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_req                  = '0;
        dout_leaf_user2interface = '0;
        vld_user2interface       = 1'b0;
        busy                     = 1'b0;
        if (w_granted) begin
            dout_leaf_user2interface = din_req[r_grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
            vld_user2interface       = w_sel_vld;
            ack_req[r_grant_idx]     = ack_interface2user;
            busy                     = 1'b1;
        end
    end

    assign grant_idx = r_grant_idx;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat [NUM_REQ];

    // Clear wins over a coinciding transfer; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || stat_clr) begin
                r_stat[i] <= '0;
            end else if (w_xfer && (r_grant_idx == REQ_BITS'(i)) && (r_stat[i] != '1)) begin
                r_stat[i] <= r_stat[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_beats[g*32 +: 32] = r_stat[g];
    end
`endif

endmodule
